// File: rtl/bit_serial_magnitude_comparator.sv
// MSB-first bit-serial magnitude comparator with one-hot E/L/G result.
// Optional BITSER_CMP_EARLY_EXIT_EN: finish at the first differing bit instead of after WIDTH bits.
module bit_serial_magnitude_comparator #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          a,
    input  logic          b,
    output logic          bit_ready,
    output logic          busy,
    output logic          done,
    output logic          E,
    output logic          L,
    output logic          G,
    output logic [CW-1:0] bit_idx
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          eq_q, eq_d;
    logic          lt_q, lt_d;
    logic          gt_q, gt_d;
    logic          e_q, e_d;
    logic          l_q, l_d;
    logic          g_q, g_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          accept;
    logic          last_beat;
    logic          finish;

    assign accept    = bit_valid && (state_q == S_COMPARE);
    assign last_beat = (idx_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        e_d     = e_q;
        l_d     = l_q;
        g_d     = g_q;
        idx_d   = idx_q;
        finish  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COMPARE;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (accept) begin
                    if (idx_q != CW'(WIDTH))
                        idx_d = idx_q + 1'b1;
                    // The first differing bit decides; later bits cannot override it.
                    if (eq_q) begin
                        if (a && !b) begin
                            gt_d = 1'b1;
                            eq_d = 1'b0;
                        end else if (!a && b) begin
                            lt_d = 1'b1;
                            eq_d = 1'b0;
                        end
                    end
`ifdef BITSER_CMP_EARLY_EXIT_EN
                    finish = last_beat || (eq_q && (a != b));
`else
                    finish = last_beat;
`endif
                    if (finish) begin
                        state_d = S_DONE;
                        e_d     = eq_d;
                        l_d     = lt_d;
                        g_d     = gt_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
            g_q     <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            e_q     <= e_d;
            l_q     <= l_d;
            g_q     <= g_d;
            idx_q   <= idx_d;
        end
    end

    assign bit_ready = (state_q == S_COMPARE);
    assign busy      = (state_q == S_COMPARE);
    assign done      = (state_q == S_DONE);
    assign E         = e_q;
    assign L         = l_q;
    assign G         = g_q;
    assign bit_idx   = idx_q;

endmodule

// File: tb/tb_bit_serial_magnitude_comparator.sv
// Directed bench for bit_serial_magnitude_comparator at WIDTH=8; honours BITSER_CMP_EARLY_EXIT_EN.
module tb_bit_serial_magnitude_comparator;

`ifdef BITSER_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       bit_ready;
    logic       busy;
    logic       done;
    logic       E;
    logic       L;
    logic       G;
    logic [3:0] bit_idx;

    int checks = 0;
    int failures = 0;

    bit_serial_magnitude_comparator #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .a(a), .b(b), .bit_ready(bit_ready), .busy(busy), .done(done),
        .E(E), .L(L), .G(G), .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; afterwards the bench sits in cycle 1 of the compare.
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drives bits [from, to) MSB first; stall=1 presents a beat only every other cycle.
    // hiccup is set if bit_ready was low or done high while beats were still owed.
    task automatic feed(input logic [7:0] av, input logic [7:0] bv, input int from,
                        input int to, input bit stall, output int cycles, output bit hiccup);
        int sent;
        int k;
        sent = from;
        k = 0;
        cycles = 0;
        hiccup = 1'b0;
        while (sent < to && k < 100) begin
            if (bit_ready !== 1'b1 || done !== 1'b0) hiccup = 1'b1;
            bit_valid = !stall || (k % 2 == 1);
            a = av[7 - sent];
            b = bv[7 - sent];
            step();
            cycles++;
            if (bit_valid) sent++;
            k++;
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({bit_ready, busy, done, E, L, G} !== 6'b0 || bit_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b busy=%b done=%b ELG=%b%b%b idx=%0d want all 0",
                     bit_ready, busy, done, E, L, G, bit_idx);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || bit_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_quiet cycle %0d got done=%b rdy=%b want 0 0", i, done, bit_ready);
            end
        end
    endtask

    task automatic test_equal();
        int cyc;
        bit hic;
        pulse_start();
        feed(8'hA5, 8'hA5, 0, 8, 1'b0, cyc, hic);
        checks++;
        if (hic || cyc + 1 != 9 || done !== 1'b1) begin
            failures++;
            $display("FAIL equal_latency got done_cycle=%0d done=%b hiccup=%b want 9 1 0", cyc + 1, done, hic);
        end
        checks++;
        if ({E, L, G} !== 3'b100 || bit_idx !== 4'd8 || busy !== 1'b0) begin
            failures++;
            $display("FAIL equal_result got ELG=%b%b%b idx=%0d busy=%b want 100 8 0", E, L, G, bit_idx, busy);
        end
        // Beats offered while idle must not move the counter.
        step();
        bit_valid = 1'b1;
        a = 1'b1;
        step();
        step();
        bit_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || {E, L, G} !== 3'b100 || bit_idx !== 4'd8 || bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL equal_hold got done=%b ELG=%b%b%b idx=%0d rdy=%b want 0 100 8 0",
                     done, E, L, G, bit_idx, bit_ready);
        end
    endtask

    task automatic test_greater_msb();
        int cyc;
        bit hic;
        int nb;
        nb = EARLY ? 1 : 8;
        pulse_start();
        feed(8'h80, 8'h7F, 0, nb, 1'b0, cyc, hic);
        checks++;
        if (hic || cyc + 1 != (EARLY ? 2 : 9) || done !== 1'b1) begin
            failures++;
            $display("FAIL greater_latency got done_cycle=%0d done=%b hiccup=%b want %0d 1 0",
                     cyc + 1, done, hic, EARLY ? 2 : 9);
        end
        checks++;
        if ({E, L, G} !== 3'b001 || bit_idx !== (EARLY ? 4'd1 : 4'd8) || bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL greater_result got ELG=%b%b%b idx=%0d rdy=%b want 001 %0d 0",
                     E, L, G, bit_idx, bit_ready, EARLY ? 1 : 8);
        end
        step();
        checks++;
        if (done !== 1'b0 || {E, L, G} !== 3'b001) begin
            failures++;
            $display("FAIL greater_done_pulse got done=%b ELG=%b%b%b want 0 001", done, E, L, G);
        end
    endtask

    task automatic test_stalled_less();
        int cyc;
        bit hic;
        pulse_start();
        feed(8'h12, 8'h13, 0, 8, 1'b1, cyc, hic);
        checks++;
        if (hic || cyc + 1 != 17 || done !== 1'b1) begin
            failures++;
            $display("FAIL stall_latency got done_cycle=%0d done=%b hiccup=%b want 17 1 0", cyc + 1, done, hic);
        end
        checks++;
        if ({E, L, G} !== 3'b010 || bit_idx !== 4'd8) begin
            failures++;
            $display("FAIL stall_result got ELG=%b%b%b idx=%0d want 010 8", E, L, G, bit_idx);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit hic;
        pulse_start();
        feed(8'hFF, 8'hFF, 0, 3, 1'b0, cyc, hic);
        checks++;
        if (bit_idx !== 4'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_progress got idx=%0d busy=%b want 3 1", bit_idx, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bit_ready, busy, done, E, L, G} !== 6'b0 || bit_idx !== 4'd0) begin
            failures++;
            $display("FAIL midreset_outputs got rdy=%b busy=%b done=%b ELG=%b%b%b idx=%0d want all 0",
                     bit_ready, busy, done, E, L, G, bit_idx);
        end
        pulse_start();
        feed(8'h01, 8'h00, 0, 8, 1'b0, cyc, hic);
        checks++;
        if (hic || cyc + 1 != 9 || done !== 1'b1 || {E, L, G} !== 3'b001 || bit_idx !== 4'd8) begin
            failures++;
            $display("FAIL midreset_restart got done_cycle=%0d done=%b ELG=%b%b%b idx=%0d want 9 1 001 8",
                     cyc + 1, done, E, L, G, bit_idx);
        end
        step();
    endtask

    task automatic test_start_ignored();
        int cyc1;
        int cyc2;
        bit hic1;
        bit hic2;
        pulse_start();
        feed(8'h5A, 8'h5A, 0, 4, 1'b0, cyc1, hic1);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (bit_idx !== 4'd4 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midstart_idx got idx=%0d busy=%b want 4 1", bit_idx, busy);
        end
        feed(8'h5A, 8'h5A, 4, 8, 1'b0, cyc2, hic2);
        checks++;
        if (hic1 || hic2 || done !== 1'b1 || {E, L, G} !== 3'b100 || bit_idx !== 4'd8) begin
            failures++;
            $display("FAIL midstart_result got done=%b ELG=%b%b%b idx=%0d hiccup=%b%b want 1 100 8 00",
                     done, E, L, G, bit_idx, hic1, hic2);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit hic;
        pulse_start();
        feed(8'h33, 8'h35, 0, EARLY ? 6 : 8, 1'b0, cyc, hic);
        checks++;
        if (hic || done !== 1'b1 || {E, L, G} !== 3'b010 || bit_idx !== (EARLY ? 4'd6 : 4'd8)) begin
            failures++;
            $display("FAIL b2b_first got done=%b ELG=%b%b%b idx=%0d hiccup=%b want 1 010 %0d 0",
                     done, E, L, G, bit_idx, hic, EARLY ? 6 : 8);
        end
        pulse_start();
        checks++;
        if (bit_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || bit_idx !== 4'd0 || {E, L, G} !== 3'b010) begin
            failures++;
            $display("FAIL b2b_no_gap got rdy=%b busy=%b done=%b idx=%0d ELG=%b%b%b want 1 1 0 0 010",
                     bit_ready, busy, done, bit_idx, E, L, G);
        end
        feed(8'hC8, 8'h48, 0, EARLY ? 1 : 8, 1'b0, cyc, hic);
        checks++;
        if (hic || cyc + 1 != (EARLY ? 2 : 9) || done !== 1'b1 || {E, L, G} !== 3'b001 ||
            bit_idx !== (EARLY ? 4'd1 : 4'd8)) begin
            failures++;
            $display("FAIL b2b_second got done_cycle=%0d done=%b ELG=%b%b%b idx=%0d want %0d 1 001 %0d",
                     cyc + 1, done, E, L, G, bit_idx, EARLY ? 2 : 9, EARLY ? 1 : 8);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {E, L, G} !== 3'b001) begin
            failures++;
            $display("FAIL b2b_settle got done=%b busy=%b ELG=%b%b%b want 0 0 001", done, busy, E, L, G);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_greater_msb();
        test_stalled_less();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
